// File: rtl/spi_reg_pkg.sv
// spi_reg_pkg: shared types and helpers for the SPI register bridge.
//   state_t        - transaction state machine encoding
//   hdr_wr_bit     - header bit index of the WR flag
//   hdr_stream_bit - header bit index of the STREAM flag
//   addr_w         - register-address width (at least 1 bit)
package spi_reg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WRT,
    ST_RD,
    ST_STRM,
    ST_DISC
  } state_t;

  function automatic int hdr_wr_bit(input int word_w);
    return word_w - 1;
  endfunction

  function automatic int hdr_stream_bit(input int word_w);
    return word_w - 2;
  endfunction

  function automatic int addr_w(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// spi_bit_engine: bit-level SPI slave datapath on synchronised pins.
//   clk_i, rst_ni - system clock, asynchronous active-low reset
//   sclk_i        - synchronised SCLK (CPOL=0)
//   mosi_i        - synchronised MOSI
//   cs_i          - synchronised chip select (active low)
//   tx_mode_i     - 1: MISO shifts out the tx register; 0: MISO echoes rx MSB
//   tx_load_i     - load tx register with tx_data_i this cycle
//   tx_data_i     - word to load into the tx register
//   miso_o        - SPI data out, updated on SCLK rising edges
//   word_done_o   - one-cycle strobe on the falling edge completing a word
//   rx_word_o     - received word, valid while word_done_o is high
//   cs_fall_o     - CS has just gone low (transaction start)
//   cs_rise_o     - CS has just gone high (transaction end)
module spi_bit_engine #(
  parameter int WORD_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sclk_i,
  input  logic              mosi_i,
  input  logic              cs_i,
  input  logic              tx_mode_i,
  input  logic              tx_load_i,
  input  logic [WORD_W-1:0] tx_data_i,
  output logic              miso_o,
  output logic              word_done_o,
  output logic [WORD_W-1:0] rx_word_o,
  output logic              cs_fall_o,
  output logic              cs_rise_o
);

  localparam int CW = $clog2(WORD_W);

  logic              sclk_q;
  logic              cs_q;
  logic [CW-1:0]     bit_cnt;
  logic [WORD_W-1:0] rx_sh;
  logic [WORD_W-1:0] tx_sh;
  logic              sclk_rise;
  logic              sclk_fall;
  logic              last_bit;

  // Edges are gated with the previous CS sample, so a falling SCLK edge that
  // lands in the same cycle as CS rising still counts and can finish a word.
  assign sclk_rise = ~cs_q & ~sclk_q &  sclk_i;
  assign sclk_fall = ~cs_q &  sclk_q & ~sclk_i;
  assign cs_fall_o =  cs_q & ~cs_i;
  assign cs_rise_o = ~cs_q &  cs_i;

  assign last_bit    = (bit_cnt == CW'(WORD_W - 1));
  assign rx_word_o   = {rx_sh[WORD_W-2:0], mosi_i};
  assign word_done_o = sclk_fall & last_bit;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      bit_cnt <= '0;
      rx_sh   <= '0;
      tx_sh   <= '0;
      miso_o  <= 1'b0;
    end else begin
      sclk_q <= sclk_i;
      cs_q   <= cs_i;

      if (sclk_fall) begin
        rx_sh   <= rx_word_o;
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end

      if (sclk_rise) begin
        if (tx_mode_i) begin
          miso_o <= tx_sh[WORD_W-1];
          tx_sh  <= {tx_sh[WORD_W-2:0], 1'b0};
        end else begin
          // The rx register is WORD_W deep, so its MSB replays the previous
          // word one word late; cleared at CS fall, it gives zeros during
          // the header.
          miso_o <= rx_sh[WORD_W-1];
        end
      end

      if (tx_load_i) begin
        tx_sh <= tx_data_i;
      end

      // Any CS edge drops a partial word and restarts the bit framing.
      if (cs_fall_o || cs_rise_o) begin
        bit_cnt <= '0;
        rx_sh   <= '0;
        tx_sh   <= '0;
        miso_o  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/synchronizer.sv
// synchronizer: FF_COUNT-stage flip-flop chain for an asynchronous input.
//   clk_i   - destination clock
//   rst_ni  - asynchronous active-low reset (chain loads RESET_VAL)
//   d_i     - asynchronous input
//   q_o     - synchronised output
module synchronizer #(
  parameter int   FF_COUNT  = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [FF_COUNT-1:0] chain;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain <= {FF_COUNT{RESET_VAL}};
    end else begin
      chain <= {chain[FF_COUNT-2:0], d_i};
    end
  end

  assign q_o = chain[FF_COUNT-1];

endmodule

// File: rtl/spi_reg_bridge.sv
// spi_reg_bridge: SPI slave front end for the shader core. Each transaction
// starts with a header word {WR, STREAM, ADDR} that selects register write
// (auto-increment), register read-back (auto-increment) or instruction stream.
//   clk_i, rst_ni        - system clock, asynchronous active-low reset
//   spi_sclk_i/mosi_i/cs_i - asynchronous SPI pins (CPOL=0, CS active low)
//   spi_miso_o           - SPI data out
//   regs_o               - packed register bank, reg n at [n*WORD_W +: WORD_W]
//   reg_wr_o             - one-cycle pulse per register write
//   reg_wr_addr_o        - register index of that write
//   stream_data_o        - last received stream word
//   stream_valid_o       - one-cycle pulse per stream word
//   bad_addr_o           - one-cycle pulse on a header with ADDR >= NUM_REGS
//   busy_o               - synchronised chip select is low
// Pulses are combinational with word completion; regs_o and stream_data_o
// take the new value on the following cycle.
module spi_reg_bridge
  import spi_reg_pkg::*;
#(
  parameter int                           WORD_W      = 8,
  parameter int                           NUM_REGS    = 4,
  parameter logic [NUM_REGS*WORD_W-1:0]   REG_DEFAULT = '0
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            spi_sclk_i,
  input  logic                            spi_mosi_i,
  input  logic                            spi_cs_i,
  output logic                            spi_miso_o,
  output logic [NUM_REGS*WORD_W-1:0]      regs_o,
  output logic                            reg_wr_o,
  output logic [addr_w(NUM_REGS)-1:0]     reg_wr_addr_o,
  output logic [WORD_W-1:0]               stream_data_o,
  output logic                            stream_valid_o,
  output logic                            bad_addr_o,
  output logic                            busy_o
);

  localparam int AW         = addr_w(NUM_REGS);
  localparam int WR_BIT     = hdr_wr_bit(WORD_W);
  localparam int STREAM_BIT = hdr_stream_bit(WORD_W);
  localparam int FW         = WORD_W - 2;

  logic sclk_s, mosi_s, cs_s;

  synchronizer #(.FF_COUNT(2), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (spi_sclk_i), .q_o (sclk_s)
  );
  synchronizer #(.FF_COUNT(2), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (spi_mosi_i), .q_o (mosi_s)
  );
  // CS resets to its idle (high) level so reset never looks like a CS fall.
  synchronizer #(.FF_COUNT(2), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i (clk_i), .rst_ni (rst_ni), .d_i (spi_cs_i), .q_o (cs_s)
  );

  logic              word_done;
  logic [WORD_W-1:0] rx_word;
  logic              cs_fall;
  logic              cs_rise;
  logic              tx_load;
  logic [WORD_W-1:0] tx_data;
  logic              tx_mode;

  state_t            state, state_n;
  logic [AW-1:0]     ptr, ptr_n;
  logic [FW-1:0]     hdr_addr;
  logic              hdr_in_range;

  spi_bit_engine #(.WORD_W(WORD_W)) u_engine (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .sclk_i      (sclk_s),
    .mosi_i      (mosi_s),
    .cs_i        (cs_s),
    .tx_mode_i   (tx_mode),
    .tx_load_i   (tx_load),
    .tx_data_i   (tx_data),
    .miso_o      (spi_miso_o),
    .word_done_o (word_done),
    .rx_word_o   (rx_word),
    .cs_fall_o   (cs_fall),
    .cs_rise_o   (cs_rise)
  );

  assign busy_o        = ~cs_s;
  assign tx_mode       = (state == ST_RD);
  assign reg_wr_addr_o = ptr;
  assign hdr_addr      = rx_word[FW-1:0];
  assign hdr_in_range  = ({1'b0, hdr_addr} < (FW + 1)'(NUM_REGS));

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
    if (p == AW'(NUM_REGS - 1)) return '0;
    return p + 1'b1;
  endfunction

  function automatic logic [WORD_W-1:0] reg_at(input logic [AW-1:0] idx,
                                                input logic [NUM_REGS*WORD_W-1:0] bank);
    return bank[idx*WORD_W +: WORD_W];
  endfunction

  always_comb begin
    state_n        = state;
    ptr_n          = ptr;
    reg_wr_o       = 1'b0;
    stream_valid_o = 1'b0;
    bad_addr_o     = 1'b0;
    tx_load        = 1'b0;
    tx_data        = '0;

    case (state)
      ST_IDLE: begin
        if (cs_fall) state_n = ST_HDR;
      end
      ST_HDR: begin
        if (word_done) begin
          if (rx_word[STREAM_BIT]) begin
            state_n = ST_STRM;
          end else if (!hdr_in_range) begin
            bad_addr_o = 1'b1;
            state_n    = ST_DISC;
          end else begin
            ptr_n = hdr_addr[AW-1:0];
            if (rx_word[WR_BIT]) begin
              state_n = ST_WRT;
            end else begin
              tx_load = 1'b1;
              tx_data = reg_at(hdr_addr[AW-1:0], regs_o);
              state_n = ST_RD;
            end
          end
        end
      end
      ST_WRT: begin
        if (word_done) begin
          reg_wr_o = 1'b1;
          ptr_n    = wrap_inc(ptr);
        end
      end
      ST_RD: begin
        if (word_done) begin
          ptr_n   = wrap_inc(ptr);
          tx_load = 1'b1;
          tx_data = reg_at(wrap_inc(ptr), regs_o);
        end
      end
      ST_STRM: begin
        if (word_done) stream_valid_o = 1'b1;
      end
      ST_DISC: begin
        state_n = ST_DISC;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // A word finishing in the CS-rise cycle is still acted on above.
    if (cs_rise) state_n = ST_IDLE;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      regs_o        <= REG_DEFAULT;
      stream_data_o <= '0;
    end else begin
      if (reg_wr_o) regs_o[ptr*WORD_W +: WORD_W] <= rx_word;
      if (stream_valid_o) stream_data_o <= rx_word;
    end
  end

endmodule
